// File: rtl/if_decode.sv
// ---------------------------------------------------------------------------
// if_decode
// Instruction fetch and pre-decode stage. Issues one fetch request at a time
// to instruction memory, holds the returned word for the downstream stage
// with a valid/ready handshake, and classifies its opcode into one-hot
// instruction-class flags for the main control decoder. Branch/jump
// redirects from the datapath squash any in-flight or held instruction.
//
// Ports
//   clk          in   1   clock, all state updates on the rising edge
//   rst_n        in   1   asynchronous active-low reset
//   imem_req     out  1   fetch request, held until imem_ack
//   imem_addr    out  32  fetch address, stable while imem_req is high
//   imem_ack     in   1   memory acknowledge, imem_rdata valid same cycle
//   imem_rdata   in   32  fetched instruction word
//   inst_valid   out  1   held instruction is presented downstream
//   inst_ready   in   1   downstream consume strobe
//   redirect     in   1   taken branch/jump
//   redirect_pc  in   32  new fetch address, sampled with redirect
//   inst         out  32  held instruction word
//   pc_out       out  32  address of the held instruction
//   Rtype..jump  out  1   one-hot instruction-class flags
//   illegal      out  1   unsupported opcode
// ---------------------------------------------------------------------------
module if_decode #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] inst,
    output logic [31:0] pc_out,
    output logic        Rtype,
    output logic        ori,
    output logic        addiu,
    output logic        lw,
    output logic        sw,
    output logic        beq,
    output logic        jump,
    output logic        illegal
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetchPc_q, fetchPc_d;
    logic        squash_q, squash_d;
    logic [31:0] squashPc_q, squashPc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pcOut_q, pcOut_d;
    // Flag order: {Rtype, ori, addiu, lw, sw, beq, jump, illegal}
    logic [7:0]  flags_q, flags_d;
    logic [7:0]  decFlags;

    // Classify the word arriving from memory so the flags can be captured
    // together with the instruction.
    always_comb begin
        case (imem_rdata[31:26])
            6'b000000: decFlags = 8'b1000_0000;
            6'b001101: decFlags = 8'b0100_0000;
            6'b001001: decFlags = 8'b0010_0000;
            6'b100011: decFlags = 8'b0001_0000;
            6'b101011: decFlags = 8'b0000_1000;
            6'b000100: decFlags = 8'b0000_0100;
            6'b000010: decFlags = 8'b0000_0010;
            default:   decFlags = 8'b0000_0001;
        endcase
    end

    // Next-state logic. A redirect seen while a request is outstanding
    // cannot move imem_addr, so it is parked in squashPc until the ack
    // arrives; a redirect coinciding with an ack supersedes any parked one.
    always_comb begin
        state_d    = state_q;
        fetchPc_d  = fetchPc_q;
        squash_d   = squash_q;
        squashPc_d = squashPc_q;
        inst_d     = inst_q;
        pcOut_d    = pcOut_q;
        flags_d    = flags_q;
        case (state_q)
            IDLE: begin
                state_d   = FETCH;
                fetchPc_d = RESET_PC;
            end
            FETCH: begin
                if (imem_ack) begin
                    if (redirect) begin
                        fetchPc_d = redirect_pc;
                        squash_d  = 1'b0;
                    end else if (squash_q) begin
                        fetchPc_d = squashPc_q;
                        squash_d  = 1'b0;
                    end else begin
                        inst_d  = imem_rdata;
                        pcOut_d = fetchPc_q;
                        flags_d = decFlags;
                        state_d = HOLD;
                    end
                end else if (redirect) begin
                    squash_d   = 1'b1;
                    squashPc_d = redirect_pc;
                end
            end
            HOLD: begin
                // Flags are cleared on exit so they are never high
                // while inst_valid is low.
                if (redirect) begin
                    fetchPc_d = redirect_pc;
                    flags_d   = 8'h00;
                    state_d   = FETCH;
                end else if (inst_ready) begin
                    fetchPc_d = pcOut_q + 32'd4;
                    flags_d   = 8'h00;
                    state_d   = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with asynchronous reset; imem_req is decoded from
    // state_q so it drops as soon as reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetchPc_q  <= RESET_PC;
            squash_q   <= 1'b0;
            squashPc_q <= RESET_PC;
            inst_q     <= 32'h0;
            pcOut_q    <= 32'h0;
            flags_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            fetchPc_q  <= fetchPc_d;
            squash_q   <= squash_d;
            squashPc_q <= squashPc_d;
            inst_q     <= inst_d;
            pcOut_q    <= pcOut_d;
            flags_q    <= flags_d;
        end
    end

    assign imem_req   = (state_q == FETCH);
    assign imem_addr  = fetchPc_q;
    assign inst_valid = (state_q == HOLD);
    assign inst       = inst_q;
    assign pc_out     = pcOut_q;
    assign Rtype      = flags_q[7];
    assign ori        = flags_q[6];
    assign addiu      = flags_q[5];
    assign lw         = flags_q[4];
    assign sw         = flags_q[3];
    assign beq        = flags_q[2];
    assign jump       = flags_q[1];
    assign illegal    = flags_q[0];

endmodule

// File: tb/tb_if_decode.sv
// ---------------------------------------------------------------------------
// tb_if_decode
// Self-checking bench for if_decode. A transaction-level reference model
// tracks what the fetch stage should be doing (requesting, holding, or
// waiting after reset) and is compared with the DUT every cycle; directed
// sequences cover the documented scenarios, followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_if_decode;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int P_IDLE  = 0;
    localparam int P_FETCH = 1;
    localparam int P_HOLD  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] inst;
    logic [31:0] pc_out;
    logic        Rtype, ori, addiu, lw, sw, beq, jump, illegal;
    logic [7:0]  obsFlags;

    int checks = 0;
    int errors = 0;

    // Model state
    int          mPhase;
    logic [31:0] mFetchPc;
    logic        mSquash;
    logic [31:0] mSquashPc;
    logic [31:0] mInst;
    logic [31:0] mPc;

    // Supported opcodes in flag order Rtype, ori, addiu, lw, sw, beq, jump
    logic [5:0] opTable [7] = '{6'h00, 6'h0D, 6'h09, 6'h23, 6'h2B, 6'h04, 6'h02};

    always #5 clk = ~clk;

    assign obsFlags = {Rtype, ori, addiu, lw, sw, beq, jump, illegal};

    if_decode #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .inst(inst), .pc_out(pc_out),
        .Rtype(Rtype), .ori(ori), .addiu(addiu), .lw(lw), .sw(sw),
        .beq(beq), .jump(jump), .illegal(illegal)
    );

    // Single comparison point: counts and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Expected flag vector from the opcode: position in the supported list,
    // or the illegal bit if the opcode is not listed.
    function automatic logic [7:0] expectFlags(input logic [5:0] op);
        for (int i = 0; i < 7; i++)
            if (op == opTable[i]) return 8'h80 >> i;
        return 8'h01;
    endfunction

    task automatic modelReset();
        mPhase    = P_IDLE;
        mFetchPc  = RESET_PC;
        mSquash   = 1'b0;
        mSquashPc = RESET_PC;
        mInst     = 32'h0;
        mPc       = 32'h0;
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic modelEdge();
        if (!rst_n) begin
            modelReset();
        end else if (mPhase == P_IDLE) begin
            mPhase   = P_FETCH;
            mFetchPc = RESET_PC;
        end else if (mPhase == P_FETCH) begin
            if (imem_ack && redirect) begin
                mFetchPc = redirect_pc;
                mSquash  = 1'b0;
            end else if (imem_ack && mSquash) begin
                mFetchPc = mSquashPc;
                mSquash  = 1'b0;
            end else if (imem_ack) begin
                mInst  = imem_rdata;
                mPc    = mFetchPc;
                mPhase = P_HOLD;
            end else if (redirect) begin
                mSquash   = 1'b1;
                mSquashPc = redirect_pc;
            end
        end else begin
            if (redirect) begin
                mFetchPc = redirect_pc;
                mPhase   = P_FETCH;
            end else if (inst_ready) begin
                mFetchPc = mPc + 32'd4;
                mPhase   = P_FETCH;
            end
        end
    endtask

    task automatic compareAll();
        checkOutput("req", 32'(imem_req), 32'(mPhase == P_FETCH));
        if (mPhase == P_FETCH) checkOutput("addr", imem_addr, mFetchPc);
        checkOutput("valid", 32'(inst_valid), 32'(mPhase == P_HOLD));
        checkOutput("flags", 32'(obsFlags),
                    (mPhase == P_HOLD) ? 32'(expectFlags(mInst[31:26])) : 32'h0);
        if (mPhase == P_HOLD) begin
            checkOutput("inst", inst, mInst);
            checkOutput("pcOut", pc_out, mPc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        compareAll();
    endtask

    // Drive one cycle of inputs, then advance and check.
    task automatic applyStimulus(input logic ack, input logic [31:0] rdata,
                                 input logic rdy, input logic redir,
                                 input logic [31:0] rpc);
        imem_ack    = ack;
        imem_rdata  = rdata;
        inst_ready  = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        tick();
    endtask

    task automatic fetchWith(input logic [31:0] rdata, input int waitCycles);
        repeat (waitCycles) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, rdata, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int illegalSeen;
        logic [31:0] rnd;
        logic [5:0]  op;

        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        modelReset();
        @(negedge clk);
        compareAll();
        checkOutput("rstAddr", imem_addr, RESET_PC);
        checkOutput("rstInst", inst, 32'h0);
        checkOutput("rstPc", pc_out, 32'h0);

        // Reset release and first fetch acked on its 2nd request cycle
        rst_n = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("firstReq", 32'(imem_req), 32'd1);
        fetchWith(32'h3421_00FF, 1);
        checkOutput("firstValid", 32'(inst_valid), 32'd1);
        checkOutput("firstOri", 32'(ori), 32'd1);
        checkOutput("firstPc", pc_out, 32'h0);

        // Stall in HOLD for five cycles, then consume
        repeat (5) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            checkOutput("stallInst", inst, 32'h3421_00FF);
            checkOutput("stallPc", pc_out, 32'h0);
            checkOutput("stallFlags", 32'(obsFlags), 32'h40);
            checkOutput("stallReq", 32'(imem_req), 32'd0);
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("nextAddr", imem_addr, 32'h4);

        // Redirect while a request is outstanding, ack 3 cycles later
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h40);
        checkOutput("squashAddrHeld", imem_addr, 32'h4);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 32'h8C00_0000, 1'b0, 1'b0, 32'h0);
        checkOutput("squashDropValid", 32'(inst_valid), 32'd0);
        checkOutput("squashNewAddr", imem_addr, 32'h40);

        // Redirect coinciding with ack
        applyStimulus(1'b1, 32'hAC00_0000, 1'b0, 1'b1, 32'h80);
        checkOutput("ackRedirValid", 32'(inst_valid), 32'd0);
        checkOutput("ackRedirAddr", imem_addr, 32'h80);

        // Redirect and inst_ready together in HOLD
        fetchWith(32'h1000_0003, 0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h100);
        checkOutput("holdRedirValid", 32'(inst_valid), 32'd0);
        checkOutput("holdRedirAddr", imem_addr, 32'h100);

        // All 64 opcodes
        illegalSeen = 0;
        for (int i = 0; i < 64; i++) begin
            rnd = $urandom;
            op  = 6'(i);
            fetchWith({op, rnd[25:0]}, int'($urandom_range(0, 2)));
            checkOutput("oneHot", 32'($countones(obsFlags)), 32'd1);
            illegalSeen += int'(illegal);
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        end
        checkOutput("illegalCount", 32'(illegalSeen), 32'd57);

        // Address wrap from the top of memory
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        fetchWith(32'h0800_0000, 0);
        checkOutput("topPc", pc_out, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("wrapAddr", imem_addr, 32'h0);

        // Asynchronous reset with a request outstanding, then a late ack
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncReqDrop", 32'(imem_req), 32'd0);
        modelReset();
        imem_ack   = 1'b1;
        imem_rdata = 32'h3421_00FF;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("lateAckValid", 32'(inst_valid), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("lateAckValid2", 32'(inst_valid), 32'd0);

        // Randomized traffic
        repeat (400) begin
            logic [31:0] data;
            logic [31:0] target;
            data = $urandom;
            if ($urandom_range(0, 1) == 1) data[31:26] = opTable[$urandom_range(0, 6)];
            target = $urandom;
            target[1:0] = 2'b00;
            applyStimulus($urandom_range(0, 2) == 0, data,
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 7) == 0, target);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_decode.md
IF_DECODE -- requirements
Module: if_decode

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, which is the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset, which is asynchronous and active-low.
REQ-004 The block SHALL have port imem_req, output, 1, the instruction-memory request, held high until acknowledged.
REQ-005 The block SHALL have port imem_addr, output, 32, the fetch address, stable while imem_req is high.
REQ-006 The block SHALL have port imem_ack, input, 1, the memory acknowledge; imem_rdata is valid in the same cycle.
REQ-007 The block SHALL have port imem_rdata, input, 32, the fetched instruction word.
REQ-008 The block SHALL have port inst_valid, output, 1, indicating that the decoded instruction is presented downstream.
REQ-009 The block SHALL have port inst_ready, input, 1, the downstream consume strobe; a transfer occurs when inst_valid and inst_ready are both high.
REQ-010 The block SHALL have port redirect, input, 1, a taken branch or jump from the datapath.
REQ-011 The block SHALL have port redirect_pc, input, 32, the new fetch address, sampled when redirect is high.
REQ-012 The block SHALL have port inst, output, 32, the held instruction word.
REQ-013 The block SHALL have port pc_out, output, 32, the address of the held instruction.
REQ-014 The block SHALL have ports Rtype, ori, addiu, lw, sw, beq and jump, each output, 1, as one-hot instruction-class flags feeding the main control decoder.
REQ-015 The block SHALL have port illegal, output, 1, set for an unsupported opcode.

Function
REQ-016 The FSM SHALL have three states: IDLE (one cycle after reset release), FETCH (imem_req high) and HOLD (inst_valid high).
REQ-017 IDLE SHALL go to FETCH on the next edge, with fetch_pc = RESET_PC.
REQ-018 In FETCH, on imem_ack with no squash pending, the block SHALL register imem_rdata into inst, register fetch_pc into pc_out, register the decoded flags, and go to HOLD; inst_valid SHALL rise in the cycle after imem_ack (1-cycle latency).
REQ-019 In FETCH without imem_ack, the block SHALL remain in FETCH with imem_req and imem_addr unchanged.
REQ-020 In HOLD with inst_ready high, the block SHALL set fetch_pc = pc_out + 4 (modulo 2^32, wrapping 32'hFFFF_FFFC to 0) and go to FETCH.
REQ-021 In HOLD with inst_ready low, the block SHALL remain in HOLD with all outputs frozen.
REQ-022 A redirect in HOLD SHALL discard the held instruction (inst_valid low next cycle, no transfer even if inst_ready is high), set fetch_pc = redirect_pc, and go to FETCH.
REQ-023 A redirect in FETCH in the same cycle as imem_ack SHALL discard the response, set fetch_pc = redirect_pc, and stay in FETCH with a new request.
REQ-024 A redirect in FETCH without imem_ack SHALL set a squash flag and latch redirect_pc; imem_addr SHALL remain unchanged until the ack; the acknowledged response SHALL then be discarded, the squash flag cleared, fetch_pc set to the latched address, and a new request issued.
REQ-025 A redirect in IDLE SHALL be ignored.
REQ-026 Decode SHALL use opcode inst[31:26]: 6'b000000 -> Rtype, 6'b001101 -> ori, 6'b001001 -> addiu, 6'b100011 -> lw, 6'b101011 -> sw, 6'b000100 -> beq, 6'b000010 -> jump; any other opcode -> illegal with all class flags 0.
REQ-027 At most one of the eight flags (seven class flags plus illegal) SHALL be high, and all SHALL be 0 whenever inst_valid is low.
REQ-028 An illegal instruction SHALL still be presented and consumed normally; this block takes no trap action.

Reset
REQ-029 While rst_n is low, the block SHALL immediately force: state = IDLE; imem_req, inst_valid and all flags = 0; inst = 0; pc_out = 0; imem_addr = RESET_PC; fetch_pc = RESET_PC; squash = 0.
REQ-030 Reset mid-FETCH SHALL abandon the request (imem_req low asynchronously), and an imem_ack arriving during or after reset SHALL be ignored until FETCH is re-entered.

Verification
REQ-031 Reset release, imem_ack on the 2nd request cycle with rdata 32'h3421_00FF -> inst_valid next cycle, ori = 1, pc_out = 0.
REQ-032 Hold inst_ready low for 5 cycles in HOLD -> inst, pc_out and flags stable and imem_req low; then inst_ready high -> next imem_addr = 32'h0000_0004.
REQ-033 Redirect to 32'h0000_0040 in FETCH, with ack 3 cycles later carrying 32'h8C00_0000 -> response dropped (inst_valid stays 0), next imem_addr = 32'h0000_0040.
REQ-034 Redirect and inst_ready together in HOLD -> no transfer, inst_valid low, next imem_addr = redirect_pc.
REQ-035 Sweep all 64 opcodes -> exactly one flag per opcode as per REQ-026, illegal for the 57 unmapped opcodes; pc_out = 32'hFFFF_FFFC consumed -> next imem_addr = 0.
REQ-036 Assert rst_n low while imem_req is high -> imem_req drops without waiting for a clock edge, and a late ack causes no inst_valid.
